// File: rtl/mlaccel_smem_responder_if.sv
`default_nettype none
// =============================================================================
// Module   : mlaccel_smem_responder_if
// Brief    : Sequencer fetch (smem) and host load port bundle for the smem responder.
// Revision : 1.0
// =============================================================================
interface mlaccel_smem_responder_if;
    logic        smem_valid;
    logic        smem_ready;
    logic [15:0] smem_addr;
    logic [31:0] smem_data;
    logic        host_valid;
    logic        host_ready;
    logic        host_we;
    logic [15:0] host_addr;
    logic [15:0] host_wdata;
    logic [15:0] host_rdata;

    modport master (
        output smem_valid, smem_addr, host_valid, host_we, host_addr, host_wdata,
        input  smem_ready, smem_data, host_ready, host_rdata
    );

    modport slave (
        input  smem_valid, smem_addr, host_valid, host_we, host_addr, host_wdata,
        output smem_ready, smem_data, host_ready, host_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mlaccel_smem_responder.sv
`default_nettype none
// =============================================================================
// Module   : mlaccel_smem_responder
// Brief    : Two-bank sequencer program memory serving 32-bit fetches from any
//            halfword address, arbitrated against a host load port.
//            Optional host read-back: MLACCEL_SMEM_HOSTRD_EN.
// Revision : 1.0
// =============================================================================
module mlaccel_smem_responder #(
    parameter int ADDR_BITS = 16
) (
    input  wire logic               clock,
    input  wire logic               resetn,
    mlaccel_smem_responder_if.slave bus
);
    localparam int IDX_BITS   = ADDR_BITS - 1;
    localparam int BANK_DEPTH = 1 << IDX_BITS;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FREAD  = 3'd1,
        FRESP  = 3'd2,
        HWRITE = 3'd3,
        HREAD  = 3'd4,
        HRESP  = 3'd5
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  last_host;
    logic                  grant_fetch;
    logic                  grant_host;
    logic                  host_is_read;
    logic [ADDR_BITS-1:0]  faddr;
    logic [ADDR_BITS-1:0]  haddr;
    logic [15:0]           even_bank [BANK_DEPTH];
    logic [15:0]           odd_bank  [BANK_DEPTH];
    logic [IDX_BITS-1:0]   f_even_idx;
    logic [IDX_BITS-1:0]   f_odd_idx;
    logic                  f_swap;
    logic                  q_swap;
    logic [15:0]           even_q;
    logic [15:0]           odd_q;
    logic                  smem_ready_q;
    logic                  host_ready_q;
    logic                  unused_addr_bits;

    assign faddr            = bus.smem_addr[ADDR_BITS-1:0];
    assign haddr            = bus.host_addr[ADDR_BITS-1:0];
    assign unused_addr_bits = ^{bus.smem_addr, bus.host_addr};

`ifdef MLACCEL_SMEM_HOSTRD_EN
    assign host_is_read = ~bus.host_we;
`else
    logic unused_host_we;
    assign unused_host_we = bus.host_we;
    assign host_is_read   = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Alternating priority: the requester that did not win the last grant wins a tie.
    always_comb begin
        state_next  = state;
        grant_fetch = 1'b0;
        grant_host  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.smem_valid && (!bus.host_valid || last_host)) begin
                    grant_fetch = 1'b1;
                    state_next  = FREAD;
                end else if (bus.host_valid) begin
                    grant_host  = 1'b1;
                    state_next  = host_is_read ? HREAD : HWRITE;
                end
            end
            FREAD:   state_next = FRESP;
            FRESP:   state_next = IDLE;
            HWRITE:  state_next = IDLE;
            HREAD:   state_next = HRESP;
            HRESP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Odd fetch addresses take the even-bank word from the next row (wrapping at the top).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_host    <= 1'b0;
            f_even_idx   <= '0;
            f_odd_idx    <= '0;
            f_swap       <= 1'b0;
            q_swap       <= 1'b0;
            even_q       <= '0;
            odd_q        <= '0;
            smem_ready_q <= 1'b0;
            host_ready_q <= 1'b0;
        end else begin
            if (grant_fetch) begin
                last_host  <= 1'b0;
                f_even_idx <= faddr[ADDR_BITS-1:1] + IDX_BITS'(faddr[0]);
                f_odd_idx  <= faddr[ADDR_BITS-1:1];
                f_swap     <= faddr[0];
            end
            if (grant_host) begin
                last_host <= 1'b1;
            end
            if (state == FREAD) begin
                even_q <= even_bank[f_even_idx];
                odd_q  <= odd_bank[f_odd_idx];
                q_swap <= f_swap;
            end
            smem_ready_q <= (state_next == FRESP);
            host_ready_q <= (state_next == HWRITE) || (state_next == HRESP);
        end
    end

    always_ff @(posedge clock) begin
        if (grant_host && !host_is_read) begin
            if (haddr[0]) begin
                odd_bank[haddr[ADDR_BITS-1:1]] <= bus.host_wdata;
            end else begin
                even_bank[haddr[ADDR_BITS-1:1]] <= bus.host_wdata;
            end
        end
    end

`ifdef MLACCEL_SMEM_HOSTRD_EN
    logic [IDX_BITS-1:0] h_idx;
    logic                h_odd;
    logic [15:0]         host_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            h_idx  <= '0;
            h_odd  <= 1'b0;
            host_q <= '0;
        end else begin
            if (grant_host) begin
                h_idx <= haddr[ADDR_BITS-1:1];
                h_odd <= haddr[0];
            end
            if (state == HREAD) begin
                host_q <= h_odd ? odd_bank[h_idx] : even_bank[h_idx];
            end
        end
    end

    assign bus.host_rdata = host_q;
`else
    assign bus.host_rdata = '0;
`endif

    assign bus.smem_data  = q_swap ? {even_q, odd_q} : {odd_q, even_q};
    assign bus.smem_ready = smem_ready_q;
    assign bus.host_ready = host_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_mlaccel_smem_responder.sv
`default_nettype none
// =============================================================================
// Module   : tb_mlaccel_smem_responder
// Brief    : Scoreboard bench for mlaccel_smem_responder (ADDR_BITS=10).
// Revision : 1.0
// =============================================================================
module tb_mlaccel_smem_responder;
    localparam int K_FETCH = 0;
    localparam int K_HWR   = 1;
    localparam int K_HRD   = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clock;
    logic resetn;
    int   cyc        = 0;
    int   compared   = 0;
    int   mismatched = 0;
    exp_t exp_q[$];

    mlaccel_smem_responder_if bus();

    mlaccel_smem_responder #(.ADDR_BITS(10)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse pops one expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.smem_ready && bus.host_ready) begin
                compared++;
                mismatched++;
                $display("FAIL both_ready: smem_ready and host_ready both 1 at cycle %0d", cyc);
            end
            if (bus.smem_ready || bus.host_ready) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_ready: smem_ready=%b host_ready=%b at cycle %0d, none expected",
                             bus.smem_ready, bus.host_ready, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.smem_ready) begin
                        if (e.kind != K_FETCH || bus.smem_data !== e.data || cyc != e.due) begin
                            mismatched++;
                            $display("FAIL fetch_resp: got kind=%0d data=%h cycle=%0d, expected kind=%0d data=%h cycle=%0d",
                                     K_FETCH, bus.smem_data, cyc, e.kind, e.data, e.due);
                        end
                    end else begin
                        if (e.kind == K_FETCH || cyc != e.due ||
                            (e.kind == K_HRD && {16'h0, bus.host_rdata} !== e.data)) begin
                            mismatched++;
                            $display("FAIL host_resp: got host pulse rdata=%h cycle=%0d, expected kind=%0d data=%h cycle=%0d",
                                     bus.host_rdata, cyc, e.kind, e.data, e.due);
                        end
                    end
                end
            end
        end
    end

    task automatic do_fetch(input logic [15:0] a, input logic [31:0] exp);
        exp_t e;
        bit   got;
        @(posedge clock); #1;
        bus.smem_valid = 1'b1;
        bus.smem_addr  = a;
        e.kind = K_FETCH; e.data = exp; e.due = cyc + 2;
        exp_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (bus.smem_ready) got = 1'b1;
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("FAIL fetch_timeout: no smem_ready for addr %h, expected within 20 cycles", a);
        end
        @(posedge clock); #1;
        bus.smem_valid = 1'b0;
    endtask

    task automatic host_req(input logic we, input logic [15:0] a, input logic [15:0] wd,
                            input logic [15:0] rd_exp);
        exp_t e;
        bit   got;
        @(posedge clock); #1;
        bus.host_valid = 1'b1;
        bus.host_we    = we;
        bus.host_addr  = a;
        bus.host_wdata = wd;
        e.data = {16'h0, rd_exp};
`ifdef MLACCEL_SMEM_HOSTRD_EN
        e.kind = we ? K_HWR : K_HRD;
`else
        e.kind = K_HWR;
`endif
        e.due = cyc + ((e.kind == K_HRD) ? 2 : 1);
        exp_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (bus.host_ready) got = 1'b1;
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("FAIL host_timeout: no host_ready for addr %h, expected within 20 cycles", a);
        end
        @(posedge clock); #1;
        bus.host_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   x;
        resetn         = 1'b0;
        bus.smem_valid = 1'b0;
        bus.smem_addr  = '0;
        bus.host_valid = 1'b0;
        bus.host_we    = 1'b1;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_smem_ready", {31'h0, bus.smem_ready}, 32'h0);
        check("rst_host_ready", {31'h0, bus.host_ready}, 32'h0);
        check("rst_smem_data",  bus.smem_data, 32'h0);
        check("rst_host_rdata", {16'h0, bus.host_rdata}, 32'h0);
        resetn = 1'b1;

        host_req(1'b1, 16'd0, 16'h1111, 16'h0);
        host_req(1'b1, 16'd1, 16'h2222, 16'h0);
        host_req(1'b1, 16'd2, 16'h3333, 16'h0);
        host_req(1'b1, 16'd3, 16'h4444, 16'h0);
        do_fetch(16'd0, 32'h2222_1111);
        do_fetch(16'd1, 32'h3333_2222);
        do_fetch(16'd2, 32'h4444_3333);
        repeat (3) @(posedge clock);
        #1;
        check("smem_data_hold", bus.smem_data, 32'h4444_3333);

        // Top-of-memory wrap and ignored upper address bits
        host_req(1'b1, 16'd1023, 16'hAAAA, 16'h0);
        host_req(1'b1, 16'd0,    16'hBBBB, 16'h0);
        do_fetch(16'd1023,  32'hBBBB_AAAA);
        do_fetch(16'h0400,  32'h2222_BBBB);
        do_fetch(16'h0401,  32'h3333_2222);

        host_req(1'b1, 16'h0404, 16'h0404, 16'h0);
        host_req(1'b1, 16'd5,    16'h1234, 16'h0);
        host_req(1'b0, 16'd5,    16'hDEAD, 16'h1234);
`ifdef MLACCEL_SMEM_HOSTRD_EN
        do_fetch(16'd4, 32'h1234_0404);
`else
        do_fetch(16'd4, 32'hDEAD_0404);
`endif

        // Both requesters held from reset: host, fetch, host, fetch
        @(posedge clock); #1;
        resetn = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        @(posedge clock); #1;
        x = cyc;
        bus.smem_valid = 1'b1;
        bus.smem_addr  = 16'd0;
        bus.host_valid = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = 16'd0;
        bus.host_wdata = 16'hC0DE;
        e.kind = K_HWR;   e.data = 32'h0;         e.due = x + 1; exp_q.push_back(e);
        e.kind = K_FETCH; e.data = 32'h2222_C0DE; e.due = x + 4; exp_q.push_back(e);
        e.kind = K_HWR;   e.data = 32'h0;         e.due = x + 6; exp_q.push_back(e);
        e.kind = K_FETCH; e.data = 32'h2222_BEEF; e.due = x + 9; exp_q.push_back(e);
        repeat (2) @(posedge clock);
        #1;
        bus.host_wdata = 16'hBEEF;
        repeat (7) @(posedge clock);
        #1;
        bus.smem_valid = 1'b0;
        bus.host_valid = 1'b0;
        repeat (3) @(posedge clock);

        // Reset one cycle after a fetch grant: no response, then a clean reissue
        @(posedge clock); #1;
        bus.smem_valid = 1'b1;
        bus.smem_addr  = 16'd2;
        @(posedge clock); #1;
        resetn         = 1'b0;
        bus.smem_valid = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        check("midrst_smem_data", bus.smem_data, 32'h0);
        repeat (5) @(posedge clock);
        do_fetch(16'd2, 32'h4444_3333);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clock);
        if (exp_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
`default_nettype wire
